apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
Synthesizable, parametrised APB master that replaces fixed-wait, pready-blind CPU-model task sequencing. It takes single read/write commands on a valid/ready port and runs APB SETUP/ACCESS phases. It honours pready wait states, captures pslverr, and aborts stalled transfers on a timeout. It sits between any bench/host sequencer and APB slaves such as the timer.

Parameters:
ADDR_W, 8, paddr/cmd_addr width.
DATA_W, 8, data width; multiple of 8, min 8.
TIMEOUT, 16, max ACCESS cycles with pready=0 before abort; 0 disables timeout.

Ports:
cpu_clk  in  1  clock, all logic on rising edge.
cpu_reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at edge.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  ADDR_W  transfer address.
cmd_wdata  in  DATA_W  write data.
cmd_strb  in  DATA_W/8  write byte strobes.
rsp_valid  out  1  one-cycle pulse, transfer complete.
rsp_rdata  out  DATA_W  read data (valid with rsp_valid on reads, else 0).
rsp_err  out  1  pslverr captured, or timeout.
rsp_timeout  out  1  transfer aborted by timeout.
busy  out  1  state != IDLE.
cpu_psel, cpu_penable, cpu_pwrite  out  1  APB control.
cpu_paddr  out  ADDR_W  APB address.
cpu_pwdata  out  DATA_W  APB write data.
cpu_pstrb  out  DATA_W/8  APB strobes.
cpu_prdata  in  DATA_W  APB read data.
cpu_pready  in  1  slave ready.
cpu_pslverr  in  1  slave error.

Behaviour:
- Clocking: one clock cpu_clk. Reset cpu_reset is synchronous, active-high.
- Reset values: all outputs 0 except cmd_ready=1; state=IDLE; timeout counter=0.
- FSM states are IDLE, SETUP, ACCESS. Outputs are registered; cmd_ready = (state==IDLE) and not in reset.
- IDLE: on cmd_valid&cmd_ready, latch the command and go to SETUP.
  - Next cycle: psel=1, penable=0, pwrite/paddr/pwdata/pstrb driven from the latched command.
- Read strobes: on reads, pwdata=0 and pstrb=0.
- SETUP: exactly one cycle, then ACCESS with penable=1. Address, data and control stay stable through ACCESS.
- ACCESS, pready=1 at edge:
  - capture prdata (reads only) and pslverr;
  - next cycle: rsp_valid=1, rsp_err=pslverr, rsp_timeout=0;
  - psel, penable, paddr, pwdata, pstrb return to 0; state returns to IDLE.
- ACCESS, pready=0:
  - timeout counter increments; it is cleared on entering SETUP.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 while pready=0, the next edge aborts: APB signals to 0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, IDLE.
  - pready=1 on that same edge wins over timeout: normal completion.
- Minimum transfer is 3 cycles from accept to rsp_valid, plus 1 cycle per wait state. No back-to-back: the next command is accepted in the rsp_valid cycle at the earliest (IDLE).
- rsp_rdata holds its last value until the next rsp_valid. rsp_err and rsp_timeout are 0 outside rsp_valid.
- pslverr is sampled only when penable&pready; otherwise it is ignored.
- Reset mid-transfer: next edge gives IDLE, APB signals 0, no rsp_valid; the latched command is dropped.
- cmd_valid while busy: ignored (cmd_ready=0); the command must be held by the sender.
- Widths: paddr and pwdata are exact copies of the cmd fields; no address alignment is enforced.

Test Plan:
- Write, zero wait: cmd addr=8'h03, wdata=8'hA5, strb=1. Required response:
  - psel rises 1 cycle after accept; penable 1 cycle later;
  - pready=1 gives rsp_valid 3 cycles after accept, rsp_err=0;
  - slave register 3 reads back 8'hA5.
- Read, 2 wait states: addr=8'h01, slave holds pready=0 for 2 ACCESS cycles and returns 8'h5C. Required response:
  - rsp_valid 5 cycles after accept, rsp_rdata=8'h5C;
  - paddr stable throughout; pstrb=0.
- Slave error: write to addr=8'h08, slave asserts pslverr with pready. Required response: rsp_err=1, rsp_timeout=0, next command accepted in the same cycle.
- Timeout: TIMEOUT=4, pready held 0. Required response:
  - abort after 4 ACCESS cycles: rsp_valid with rsp_err=1, rsp_timeout=1;
  - psel=0 the same cycle.
  - With pready=1 on the 4th ACCESS cycle instead: normal completion, rsp_timeout=0.
- Reset mid-ACCESS: assert cpu_reset during wait state. Required response:
  - next cycle psel=penable=0, cmd_ready=1;
  - no rsp_valid ever for the dropped transfer.
- Parametrised: DATA_W=32, ADDR_W=12, write 32'hDEADBEEF with strb=4'b0101 to 12'h804. Required response: pwdata, pstrb and paddr exact, and read-back matches the masked bytes.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB master: accepts single read/write commands on a valid/ready port and runs
// SETUP/ACCESS phases with pready wait states, pslverr capture and a stall timeout.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  cpu_psel,
  output logic                  cpu_penable,
  output logic                  cpu_pwrite,
  output logic [ADDR_W-1:0]     cpu_paddr,
  output logic [DATA_W-1:0]     cpu_pwdata,
  output logic [DATA_W/8-1:0]   cpu_pstrb,
  input  logic [DATA_W-1:0]     cpu_prdata,
  input  logic                  cpu_pready,
  input  logic                  cpu_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;

  // The APB output registers double as the latched command for the transfer.
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q   <= SETUP;
            cnt_q     <= '0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_write ? cmd_wdata : '0;
            pstrb_q   <= cmd_write ? cmd_strb  : '0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (cpu_pready) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : cpu_prdata;
            rsp_err_q   <= cpu_pslverr;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            // Slave stalled too long: abandon the transfer and report it.
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE) && !cpu_reset;
  assign busy        = (state_q != IDLE);
  assign cpu_psel    = psel_q;
  assign cpu_penable = penable_q;
  assign cpu_pwrite  = pwrite_q;
  assign cpu_paddr   = paddr_q;
  assign cpu_pwdata  = pwdata_q;
  assign cpu_pstrb   = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed and random commands against a scripted APB
// slave, with a transaction-level reference model feeding a scoreboard monitor.
module tb_apb_master_ctrl;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          cpu_reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic          cpu_psel;
  logic          cpu_penable;
  logic          cpu_pwrite;
  logic [AW-1:0] cpu_paddr;
  logic [DW-1:0] cpu_pwdata;
  logic [SW-1:0] cpu_pstrb;
  logic [DW-1:0] cpu_prdata = '0;
  logic          cpu_pready = 1'b0;
  logic          cpu_pslverr = 1'b0;

  apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .cpu_clk(clk), .cpu_reset(cpu_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .cpu_psel(cpu_psel), .cpu_penable(cpu_penable), .cpu_pwrite(cpu_pwrite),
    .cpu_paddr(cpu_paddr), .cpu_pwdata(cpu_pwdata), .cpu_pstrb(cpu_pstrb),
    .cpu_prdata(cpu_prdata), .cpu_pready(cpu_pready), .cpu_pslverr(cpu_pslverr)
  );

  typedef struct {
    int            acc;
    int            lat;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [SW-1:0] st;
    logic [DW-1:0] rd;
    bit            err;
    bit            to;
  } exp_t;

  typedef struct {
    int waits;
    bit err;
  } beh_t;

  exp_t          sb[$];
  beh_t          bq[$];
  logic [DW-1:0] mdl  [16];
  logic [DW-1:0] smem [16];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            last_done = 0;
  logic [DW-1:0] last_rd = '0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #2000000; $display("FAIL watchdog: run did not finish"); $fatal(1); end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [SW-1:0] st);
    logic [DW-1:0] r = old;
    for (int b = 0; b < SW; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Scripted slave: pready on the (waits+1)th ACCESS cycle, noise on ignored inputs.
  initial begin
    beh_t cur = '{0, 1'b0};
    int   acc_n = 0;
    forever begin
      @(negedge clk);
      if (cpu_psel && !cpu_penable) begin
        if (bq.size() > 0) cur = bq.pop_front(); else cur = '{0, 1'b0};
        acc_n = 0;
        cpu_pready  = 1'($urandom);
        cpu_pslverr = 1'($urandom);
        cpu_prdata  = $urandom;
      end else if (cpu_psel && cpu_penable) begin
        if (acc_n == cur.waits) begin
          cpu_pready  = 1'b1;
          cpu_pslverr = cur.err;
          cpu_prdata  = smem[cpu_paddr[3:0]];
          if (cpu_pwrite && !cur.err)
            smem[cpu_paddr[3:0]] = merge(smem[cpu_paddr[3:0]], cpu_pwdata, cpu_pstrb);
        end else begin
          cpu_pready  = 1'b0;
          cpu_pslverr = 1'($urandom);
          cpu_prdata  = $urandom;
        end
        acc_n++;
      end else begin
        cpu_pready  = 1'($urandom);
        cpu_pslverr = 1'($urandom);
        cpu_prdata  = $urandom;
      end
    end
  end

  // Monitor: checks APB phase shape and the response against the scoreboard head.
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (cpu_reset) begin
        last_rd = '0;
      end else if (sb.size() > 0 && cyc > sb[0].acc) begin
        e = sb[0];
        d = cyc - e.acc;
        if (d < e.lat) begin
          chk("psel in transfer", 32'(cpu_psel), 32'(1));
          chk("penable phase", 32'(cpu_penable), 32'(d >= 2));
          chk("early rsp_valid", 32'(rsp_valid), 32'(0));
          chk("paddr", 32'(cpu_paddr), 32'(e.addr));
          chk("pwrite", 32'(cpu_pwrite), 32'(e.wr));
          chk("pwdata", cpu_pwdata, e.wr ? e.wd : 32'h0);
          chk("pstrb", 32'(cpu_pstrb), e.wr ? 32'(e.st) : 32'h0);
          chk("cmd_ready busy", 32'(cmd_ready), 32'(0));
          chk("busy", 32'(busy), 32'(1));
          chk("rsp_err idle", 32'(rsp_err), 32'(0));
          chk("rsp_rdata hold", rsp_rdata, last_rd);
        end else begin
          chk("rsp_valid", 32'(rsp_valid), 32'(1));
          chk("rsp_rdata", rsp_rdata, e.rd);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          chk("psel after rsp", 32'(cpu_psel), 32'(0));
          chk("penable after rsp", 32'(cpu_penable), 32'(0));
          chk("paddr after rsp", 32'(cpu_paddr), 32'(0));
          chk("pwdata after rsp", cpu_pwdata, 32'h0);
          chk("pstrb after rsp", 32'(cpu_pstrb), 32'(0));
          chk("cmd_ready at rsp", 32'(cmd_ready), 32'(1));
          last_rd = rsp_rdata;
          void'(sb.pop_front());
        end
      end else begin
        chk("unexpected rsp_valid", 32'(rsp_valid), 32'(0));
        chk("psel idle", 32'(cpu_psel), 32'(0));
        chk("penable idle", 32'(cpu_penable), 32'(0));
        chk("busy idle", 32'(busy), 32'(0));
        chk("cmd_ready idle", 32'(cmd_ready), 32'(1));
        chk("rsp_err idle", 32'(rsp_err), 32'(0));
        chk("rsp_timeout idle", 32'(rsp_timeout), 32'(0));
        chk("rsp_rdata hold", rsp_rdata, last_rd);
      end
    end
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input int waits, input bit serr);
    exp_t e;
    int   start;
    int   guard = 0;
    @(negedge clk);
    cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st; cmd_valid = 1'b1;
    bq.push_back('{waits, serr});
    start = cyc;
    while (!cmd_ready && guard < 64) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin
      $display("FAIL accept: cmd_ready never rose within 64 cycles");
      $fatal(1);
    end
    if (start <= last_done) chk("accept in rsp cycle", 32'(cyc), 32'(last_done));
    e.acc  = cyc;
    e.to   = (waits >= TMO);
    e.lat  = 3 + (e.to ? TMO - 1 : waits);
    e.wr   = wr; e.addr = a; e.wd = wd; e.st = st;
    e.err  = e.to || serr;
    e.rd   = (!wr && !e.to) ? mdl[a[3:0]] : '0;
    if (wr && !e.to && !serr) mdl[a[3:0]] = merge(mdl[a[3:0]], wd, st);
    sb.push_back(e);
    last_done = e.acc + e.lat;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
    cmd_wdata = $urandom; cmd_strb = SW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mdl[i] = '0; smem[i] = '0; end
    repeat (3) @(negedge clk);
    chk("cmd_ready in reset", 32'(cmd_ready), 32'(0));
    @(posedge clk); #1 cpu_reset = 1'b0;
    @(negedge clk);
    chk("reset cmd_ready", 32'(cmd_ready), 32'(1));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset psel", 32'(cpu_psel), 32'(0));
    chk("reset penable", 32'(cpu_penable), 32'(0));
    chk("reset pwrite", 32'(cpu_pwrite), 32'(0));
    chk("reset paddr", 32'(cpu_paddr), 32'(0));
    chk("reset pwdata", cpu_pwdata, 32'h0);
    chk("reset pstrb", 32'(cpu_pstrb), 32'(0));
    chk("reset rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'(0));
    chk("reset rsp_timeout", 32'(rsp_timeout), 32'(0));

    issue(1'b1, 12'h003, 32'h0000_00A5, 4'b0001, 0, 1'b0);
    issue(1'b0, 12'h003, 32'h0, 4'b0, 0, 1'b0);
    issue(1'b1, 12'h001, 32'h0000_005C, 4'b0001, 1, 1'b0);
    issue(1'b0, 12'h001, 32'h0, 4'b0, 2, 1'b0);
    issue(1'b1, 12'h008, 32'h0000_0077, 4'b0001, 0, 1'b1);
    issue(1'b0, 12'h008, 32'h0, 4'b0, 0, 1'b0);
    issue(1'b0, 12'h003, 32'h0, 4'b0, 4, 1'b0);
    issue(1'b0, 12'h003, 32'h0, 4'b0, 3, 1'b0);
    issue(1'b1, 12'h005, 32'h1234_5678, 4'b1111, 9, 1'b0);
    issue(1'b1, 12'h804, 32'hDEAD_BEEF, 4'b0101, 0, 1'b0);
    issue(1'b0, 12'h804, 32'h0, 4'b0, 1, 1'b0);

    // Reset during a wait state drops the transfer without a response.
    issue(1'b0, 12'h00A, 32'h0, 4'b0, 20, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cpu_reset = 1'b1;
    sb.delete();
    last_done = 0;
    @(posedge clk); #1 cpu_reset = 1'b0;
    @(negedge clk);
    chk("psel after mid reset", 32'(cpu_psel), 32'(0));
    chk("penable after mid reset", 32'(cpu_penable), 32'(0));
    chk("cmd_ready after mid reset", 32'(cmd_ready), 32'(1));
    repeat (12) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
            int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0));
    end

    repeat (12) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
